// File: rtl/jtgng_rom_arb.sv
// Arbitrates one ROM port between NCLI round-robin read clients and a
// single-entry download write buffer. Buffered writes always win over reads.
module jtgng_rom_arb #(
  parameter int AW   = 19,
  parameter int DW   = 8,
  parameter int NCLI = 3,
  parameter int LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dl_active,
  input  logic               dl_wr,
  input  logic [AW-1:0]      dl_addr,
  input  logic [DW-1:0]      dl_data,
  output logic               dl_ovf,
  input  logic [NCLI-1:0]    cli_req,
  input  logic [NCLI*AW-1:0] cli_addr,
  output logic [NCLI-1:0]    cli_ack,
  output logic [DW-1:0]      cli_dout,
  output logic               busy,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int PW = (NCLI > 1) ? $clog2(NCLI) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              wbuf_v_q, wbuf_v_d;
  logic [AW-1:0]     wbuf_addr_q, wbuf_addr_d;
  logic [DW-1:0]     wbuf_data_q, wbuf_data_d;
  logic              dl_ovf_q, dl_ovf_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NCLI-1:0]   cli_ack_q, cli_ack_d;
  logic [DW-1:0]     cli_dout_q, cli_dout_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  logic              drain_s;
  logic [NCLI-1:0]   req_eff_s;
  logic [PW:0]       pick_s;

  // Returns {found, index} of the first requester strictly after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NCLI-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0]   res;
    logic [PW-1:0] sel;
    res = {(PW+1){1'b0}};
    for (int i = NCLI; i >= 1; i--) begin
      sel = PW'((int'(ptr) + i) % NCLI);
      if (req[sel]) begin
        res = {1'b1, sel};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // A client whose ack is high this cycle is still holding req; it must not be regranted.
  assign req_eff_s = cli_req & ~cli_ack_q;
  assign pick_s    = rr_pick(req_eff_s, rr_q);
  assign drain_s   = (state_q == IDLE) && wbuf_v_q;

  always_comb begin
    wbuf_v_d    = wbuf_v_q;
    wbuf_addr_d = wbuf_addr_q;
    wbuf_data_d = wbuf_data_q;
    dl_ovf_d    = dl_ovf_q;
    if (dl_wr) begin
      if (!wbuf_v_q || drain_s) begin
        wbuf_v_d    = 1'b1;
        wbuf_addr_d = dl_addr;
        wbuf_data_d = dl_data;
      end else begin
        dl_ovf_d = 1'b1;
      end
    end else if (drain_s) begin
      wbuf_v_d = 1'b0;
    end else begin
      wbuf_v_d = wbuf_v_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    cli_ack_d   = {NCLI{1'b0}};
    cli_dout_d  = cli_dout_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (wbuf_v_q) begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = wbuf_addr_q;
          mem_wdata_d = wbuf_data_q;
          state_d     = WRITE;
        end else if (!dl_active && pick_s[PW]) begin
          gnt_d      = pick_s[PW-1:0];
          rr_d       = pick_s[PW-1:0];
          mem_rd_d   = 1'b1;
          mem_addr_d = cli_addr[int'(pick_s[PW-1:0])*AW +: AW];
          cnt_d      = {CW{1'b0}};
          state_d    = READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      READ: begin
        // cnt_q == LAT marks the cycle mem_rdata is valid for the issued read.
        if (cnt_q == CW'(LAT)) begin
          cli_dout_d       = mem_rdata;
          cli_ack_d[gnt_q] = 1'b1;
          state_d          = IDLE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wbuf_v_q    <= 1'b0;
      wbuf_addr_q <= {AW{1'b0}};
      wbuf_data_q <= {DW{1'b0}};
      dl_ovf_q    <= 1'b0;
      rr_q        <= PW'(NCLI - 1);
      gnt_q       <= {PW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      cli_ack_q   <= {NCLI{1'b0}};
      cli_dout_q  <= {DW{1'b0}};
      mem_addr_q  <= {AW{1'b0}};
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= {DW{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbuf_v_q    <= wbuf_v_d;
      wbuf_addr_q <= wbuf_addr_d;
      wbuf_data_q <= wbuf_data_d;
      dl_ovf_q    <= dl_ovf_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      cli_ack_q   <= cli_ack_d;
      cli_dout_q  <= cli_dout_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign dl_ovf    = dl_ovf_q;
  assign cli_ack   = cli_ack_q;
  assign cli_dout  = cli_dout_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_jtgng_rom_arb.sv
// Directed bench for jtgng_rom_arb: ROM model with LAT-cycle read pipeline,
// scoreboard queues for expected reads (acks) and writes (mem_wr).
module tb_jtgng_rom_arb;
  localparam int AW = 19, DW = 8, NCLI = 3, LAT = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic dl_active = 1'b0, dl_wr = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [DW-1:0] dl_data = '0;
  logic dl_ovf;
  logic [NCLI-1:0] cli_req = '0;
  logic [NCLI*AW-1:0] cli_addr = '0;
  logic [NCLI-1:0] cli_ack;
  logic [DW-1:0] cli_dout;
  logic busy;
  logic [AW-1:0] mem_addr;
  logic mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  jtgng_rom_arb #(.AW(AW), .DW(DW), .NCLI(NCLI), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .dl_data(dl_data), .dl_ovf(dl_ovf), .cli_req(cli_req), .cli_addr(cli_addr),
    .cli_ack(cli_ack), .cli_dout(cli_dout), .busy(busy), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ROM model: writes land in rom[], reads return data LAT cycles after mem_rd.
  logic [DW-1:0] rom [logic [AW-1:0]];
  logic pv0 = 1'b0, pv1 = 1'b0;
  logic [DW-1:0] pd0 = '0, pd1 = '0;

  function automatic logic [DW-1:0] rom_rd(input logic [AW-1:0] a);
    if (rom.exists(a)) return rom[a];
    if (a == 19'h01234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    pv0 <= mem_rd;
    pd0 <= rom_rd(mem_addr);
    pv1 <= pv0;
    pd1 <= pd0;
    if (mem_wr) rom[mem_addr] = mem_wdata;
  end
  assign mem_rdata = pv1 ? pd1 : 8'hEE;

  typedef struct { logic [NCLI-1:0] ack; logic [AW-1:0] addr; logic [DW-1:0] data; } rd_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int ack_cycs[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, ack_cnt = 0, rd_issued = 0;
  int last_rd_cyc = 0, last_ack_cyc = 0, last_wr_cyc = 0;
  int stop_at = 0;
  logic hold_req = 1'b0;
  logic [NCLI-1:0] drop_mask = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rd_exp_t mk_rd(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_exp_t e;
    e.ack = NCLI'(1) << c;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  task automatic set_addr(input int c, input logic [AW-1:0] a);
    cli_addr[c*AW +: AW] = a;
  endtask

  // One clock: clients drop acked req just after the edge, then outputs are scored at negedge.
  task automatic step();
    rd_exp_t e;
    wr_exp_t w;
    @(posedge clk);
    #1;
    cli_req = cli_req & ~drop_mask;
    drop_mask = '0;
    @(negedge clk);
    cyc++;
    if (mem_rd && mem_wr) check("rd_wr_exclusive", 32'(mem_wr), 32'd0);
    if (mem_rd) begin
      rd_issued++;
      last_rd_cyc = cyc;
      check("rd_expected", 32'(rd_q.size() > 0), 32'd1);
      if (rd_q.size() > 0) check("rd_addr", 32'(mem_addr), 32'(rd_q[0].addr));
    end
    if (mem_wr) begin
      last_wr_cyc = cyc;
      check("wr_expected", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.addr));
        check("wr_data", 32'(mem_wdata), 32'(w.data));
      end
    end
    if (cli_ack != '0) begin
      ack_cnt++;
      last_ack_cyc = cyc;
      ack_cycs.push_back(cyc);
      check("ack_expected", 32'(rd_q.size() > 0), 32'd1);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        check("ack_vec", 32'(cli_ack), 32'(e.ack));
        check("ack_dout", 32'(cli_dout), 32'(e.data));
      end
      if (!hold_req) drop_mask = cli_ack;
      if (stop_at != 0 && ack_cnt == stop_at) cli_req = '0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_acks(input int n, input int budget);
    int start, k;
    start = ack_cnt;
    k = 0;
    while (ack_cnt < start + n && k < budget) begin
      step();
      k++;
    end
    check("ack_timeout", 32'(ack_cnt - start), 32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cli_req = '0;
    dl_wr = 1'b0;
    dl_active = 1'b0;
    hold_req = 1'b0;
    stop_at = 0;
    drop_mask = '0;
    rd_q.delete();
    wr_q.delete();
    steps(2);
    rst = 1'b0;
    step();
  endtask

  int req_cyc, drop_cyc, rd_before;

  initial begin
    do_reset();
    check("rst_ack", 32'(cli_ack), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_ovf", 32'(dl_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(cli_dout), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);

    // Single read from client 1
    set_addr(1, 19'h01234);
    cli_req = 3'b010;
    rd_q.push_back(mk_rd(1, 19'h01234, 8'hA5));
    req_cyc = cyc;
    step();
    check("t1_busy", 32'(busy), 32'd1);
    wait_acks(1, 20);
    check("t1_rd_cycle", 32'(last_rd_cyc - req_cyc), 32'd1);
    check("t1_ack_cycle", 32'(last_ack_cyc - req_cyc), 32'd4);
    steps(6);
    check("t1_dout_held", 32'(cli_dout), 32'hA5);
    check("t1_idle", 32'(busy), 32'd0);

    // Round-robin with all three requesting from reset
    do_reset();
    set_addr(0, 19'h00010);
    set_addr(1, 19'h00021);
    set_addr(2, 19'h00032);
    rd_q.push_back(mk_rd(0, 19'h00010, rom_rd(19'h00010)));
    rd_q.push_back(mk_rd(1, 19'h00021, rom_rd(19'h00021)));
    rd_q.push_back(mk_rd(2, 19'h00032, rom_rd(19'h00032)));
    rd_q.push_back(mk_rd(0, 19'h00010, rom_rd(19'h00010)));
    rd_q.push_back(mk_rd(1, 19'h00021, rom_rd(19'h00021)));
    hold_req = 1'b1;
    stop_at = ack_cnt + 5;
    ack_cycs.delete();
    req_cyc = cyc;
    cli_req = 3'b111;
    wait_acks(5, 60);
    check("t2_first_ack", 32'(ack_cycs[0] - req_cyc), 32'd4);
    for (int i = 1; i < 5; i++) check("t2_ack_spacing", 32'(ack_cycs[i] - ack_cycs[i-1]), 32'd4);
    hold_req = 1'b0;
    stop_at = 0;
    steps(6);

    // Download write arriving during a read
    set_addr(0, 19'h00100);
    cli_req = 3'b001;
    rd_q.push_back(mk_rd(0, 19'h00100, rom_rd(19'h00100)));
    step();
    dl_wr = 1'b1; dl_addr = 19'h40000; dl_data = 8'h5A;
    wr_q.push_back('{addr: 19'h40000, data: 8'h5A});
    step();
    dl_wr = 1'b0;
    wait_acks(1, 20);
    step();
    check("t3_wr_after_ack", 32'(last_wr_cyc - last_ack_cyc), 32'd1);
    check("t3_no_ovf", 32'(dl_ovf), 32'd0);
    check("t3_wr_drained", 32'(wr_q.size()), 32'd0);
    set_addr(2, 19'h40000);
    cli_req = 3'b100;
    rd_q.push_back(mk_rd(2, 19'h40000, 8'h5A));
    wait_acks(1, 20);
    steps(3);

    // Back-to-back writes during a read: second one overflows
    set_addr(1, 19'h00200);
    cli_req = 3'b010;
    rd_q.push_back(mk_rd(1, 19'h00200, rom_rd(19'h00200)));
    step();
    dl_wr = 1'b1; dl_addr = 19'h00300; dl_data = 8'h11;
    wr_q.push_back('{addr: 19'h00300, data: 8'h11});
    step();
    dl_addr = 19'h00301; dl_data = 8'h22;
    step();
    dl_wr = 1'b0;
    check("t4_ovf_set", 32'(dl_ovf), 32'd1);
    wait_acks(1, 20);
    steps(4);
    check("t4_ovf_sticky", 32'(dl_ovf), 32'd1);
    check("t4_one_write", 32'(wr_q.size()), 32'd0);

    // Reset in the middle of a read with a write buffered
    set_addr(2, 19'h00400);
    cli_req = 3'b100;
    rd_q.push_back(mk_rd(2, 19'h00400, rom_rd(19'h00400)));
    step();
    dl_wr = 1'b1; dl_addr = 19'h00500; dl_data = 8'h33;
    step();
    dl_wr = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_ack", 32'(cli_ack), 32'd0);
    check("t6_mem_rd", 32'(mem_rd), 32'd0);
    check("t6_mem_wr", 32'(mem_wr), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ovf", 32'(dl_ovf), 32'd0);
    rd_q.delete();
    wr_q.delete();
    cli_req = '0;
    steps(2);
    rst = 1'b0;
    steps(8);
    check("t6_after_busy", 32'(busy), 32'd0);

    // dl_active blocks grants; a write is still accepted meanwhile
    dl_active = 1'b1;
    set_addr(0, 19'h00600);
    cli_req = 3'b001;
    rd_before = rd_issued;
    dl_wr = 1'b1; dl_addr = 19'h00700; dl_data = 8'h77;
    wr_q.push_back('{addr: 19'h00700, data: 8'h77});
    step();
    dl_wr = 1'b0;
    steps(20);
    check("t5_no_read", 32'(rd_issued - rd_before), 32'd0);
    check("t5_write_done", 32'(wr_q.size()), 32'd0);
    rd_q.push_back(mk_rd(0, 19'h00600, rom_rd(19'h00600)));
    dl_active = 1'b0;
    drop_cyc = cyc;
    wait_acks(1, 20);
    check("t5_ack_latency", 32'(last_ack_cyc - drop_cyc), 32'd4);
    steps(4);
    check("t5_no_pending", 32'(rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
